// File: rtl/nios2_lcd_pkg.sv
// Shared constants for the timed HD44780/16207 character-LCD controller.
package nios2_lcd_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ST_W-1:0] ST_PULSE = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
    localparam logic [ST_W-1:0] ST_POLL  = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

    localparam int unsigned LCD_ADDR_RW  = 0;
    localparam int unsigned LCD_ADDR_RS  = 1;
    localparam int unsigned LCD_BUSY_BIT = 7;

    // Largest of the three phase lengths; sizes the shared phase timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nios2_lcd_phase_timer.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
module nios2_lcd_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/nios2_lcd_timed_ctrl.sv
// Avalon-MM character-LCD controller generating the E/RS/RW bus cycle in hardware.
// Optional busy-flag polling after every write: define LCD_BUSY_POLL_EN.
module nios2_lcd_timed_ctrl
    import nios2_lcd_pkg::*;
#(
    parameter int unsigned BUS4     = 0,
    parameter int unsigned T_AS     = 2,
    parameter int unsigned T_PW     = 12,
    parameter int unsigned T_H      = 2,
    parameter int unsigned POLL_MAX = 4095
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int unsigned TMR_W = $clog2(max3(T_AS, T_PW, T_H) + 1);

    if (T_AS < 1 || T_PW < 1 || T_H < 1 || POLL_MAX < 1) begin : g_param_check
        $error("nios2_lcd_timed_ctrl: T_AS, T_PW, T_H and POLL_MAX must be at least 1");
    end

    logic [ST_W-1:0]  state, state_d;
    logic             rs_d, rw_d, e_d;
    logic [7:0]       wdata, wdata_d;
    logic             nib, nib_d;
    logic             bus_drive, drive_d;
    logic [7:0]       rdata_d;
    logic [7:0]       bus_out;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

`ifdef LCD_BUSY_POLL_EN
    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

    logic [POLL_W-1:0] poll_cnt, poll_d;
    logic              poll_req, poll_req_d;
`endif

    nios2_lcd_phase_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state, latched request and registered-output values
    always_comb begin
        state_d  = state;
        rs_d     = LCD_RS;
        rw_d     = LCD_RW;
        wdata_d  = wdata;
        nib_d    = nib;
        rdata_d  = readdata;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef LCD_BUSY_POLL_EN
        poll_d     = poll_cnt;
        poll_req_d = poll_req;
`endif
        case (state)
            ST_IDLE: begin
                if (read || write) begin
                    rs_d     = address[LCD_ADDR_RS];
                    rw_d     = address[LCD_ADDR_RW] | read;
                    wdata_d  = writedata;
                    nib_d    = 1'b0;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_AS - 1);
`ifdef LCD_BUSY_POLL_EN
                    poll_d     = '0;
                    poll_req_d = ~(address[LCD_ADDR_RW] | read);
`endif
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_PW - 1);
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    // The LCD drives its data late in the E pulse, so sample on the last clock
                    if (LCD_RW) begin
                        if (BUS4 != 0) begin
                            if (nib) rdata_d[3:0] = LCD_data[7:4];
                            else     rdata_d[7:4] = LCD_data[7:4];
                        end else begin
                            rdata_d = LCD_data;
                        end
                    end
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_H - 1);
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    if (BUS4 != 0 && !nib) begin
                        nib_d    = 1'b1;
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(T_AS - 1);
                    end else begin
`ifdef LCD_BUSY_POLL_EN
                        state_d = poll_req ? ST_POLL : ST_DONE;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef LCD_BUSY_POLL_EN
            ST_POLL: begin
                // First visit always issues a read; later visits judge the last busy byte
                if (poll_cnt != '0 &&
                    (!readdata[LCD_BUSY_BIT] || poll_cnt == POLL_W'(POLL_MAX))) begin
                    state_d = ST_DONE;
                end else begin
                    poll_d   = poll_cnt + POLL_W'(1);
                    rs_d     = 1'b0;
                    rw_d     = 1'b1;
                    nib_d    = 1'b0;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_AS - 1);
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        e_d     = (state_d == ST_PULSE);
        drive_d = !rw_d && (state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            LCD_E     <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b1;
            bus_drive <= 1'b0;
            wdata     <= '0;
            nib       <= 1'b0;
            readdata  <= '0;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt  <= '0;
            poll_req  <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            LCD_E     <= e_d;
            LCD_RS    <= rs_d;
            LCD_RW    <= rw_d;
            bus_drive <= drive_d;
            wdata     <= wdata_d;
            nib       <= nib_d;
            readdata  <= rdata_d;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt  <= poll_d;
            poll_req  <= poll_req_d;
`endif
        end
    end

    // 4-bit mode sends the high nibble first on [7:4] with [3:0] held low
    always_comb begin
        bus_out = wdata;
        if (BUS4 != 0) begin
            bus_out = {(nib ? wdata[3:0] : wdata[7:4]), 4'b0000};
        end
    end

    assign LCD_data    = bus_drive ? bus_out : 8'bz;
    assign waitrequest = (read || write) && (state != ST_DONE);

endmodule
